pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_sat_cnt.sv | 30 +++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_EX_WAIT = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_ERR     = 2'd3
   } state_t;

   localparam int STALL_PC    = 0;
   localparam int STALL_IF_ID = 1;
   localparam int STALL_ID_EX = 2;
   localparam int STALL_EX_MEM = 3;
   localparam int STALL_MEM_WB = 4;
   localparam int STALL_WB    = 5;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ALL  = 6'b111111;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with async active-low clear; reusable for perf counters.
module sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with EX-stall watchdog and stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; ID/EX stall requests applied combinationally
// EX_WAIT  | multi-cycle EX op busy; watchdog counting consecutive EX stalls
// FLUSH    | one-cycle pipeline clear, PC loads new_pc
// ERR      | watchdog expired; everything held until reset
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MAX_EX_STALL = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        excp_req,
   input  logic [31:0] excp_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        timeout_err,
   output logic [31:0] stall_cycles
);

   localparam int CNT_W = $clog2(MAX_EX_STALL + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_EX_STALL);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_EX_STALL - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   ex_cnt_q, ex_cnt_d;
   logic [31:0]        new_pc_q, new_pc_d;
   logic               flush_q, flush_d;
   logic               err_q, err_d;

   always_comb begin
      if (state_q == ST_ERR) begin
         stall = STALL_ALL;
      end else if ((state_q == ST_FLUSH) || excp_req) begin
         stall = STALL_NONE;
      end else if (stallreq_ex) begin
         stall = STALL_EX;
      end else if (stallreq_id) begin
         stall = STALL_ID;
      end else begin
         stall = STALL_NONE;
      end
   end

   always_comb begin
      state_d  = state_q;
      ex_cnt_d = ex_cnt_q;
      new_pc_d = new_pc_q;
      if (state_q != ST_ERR) begin
         if (excp_req) begin
            new_pc_d = excp_pc;
         end
         // Watchdog counts only cycles that actually held the pipe with the EX pattern.
         if (stall == STALL_EX) begin
            ex_cnt_d = (ex_cnt_q == CNT_MAX) ? ex_cnt_q : ex_cnt_q + CNT_ONE;
         end else begin
            ex_cnt_d = '0;
         end
      end
      unique case (state_q)
         ST_RUN: begin
            if (excp_req)         state_d = ST_FLUSH;
            else if (stallreq_ex) state_d = ST_EX_WAIT;
         end
         ST_EX_WAIT: begin
            if (excp_req)                   state_d = ST_FLUSH;
            else if (!stallreq_ex)          state_d = ST_RUN;
            else if (ex_cnt_q >= CNT_LIMIT) state_d = ST_ERR;
         end
         ST_FLUSH: begin
            state_d = excp_req ? ST_FLUSH : ST_RUN;
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: state_d = ST_RUN;
      endcase
      flush_d = (state_d == ST_FLUSH);
      err_d   = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_RUN;
         ex_cnt_q <= '0;
         new_pc_q <= 32'h0000_0000;
         flush_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ex_cnt_q <= ex_cnt_d;
         new_pc_q <= new_pc_d;
         flush_q  <= flush_d;
         err_q    <= err_d;
      end
   end

   sat_cnt #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (stall[STALL_PC]),
      .cnt   (stall_cycles)
   );

   assign flush       = flush_q;
   assign new_pc      = new_pc_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a reference model.
module tb_pipe_ctrl;

   localparam int MAX = 4;
   localparam logic [5:0] P_ID  = 6'b000111;
   localparam logic [5:0] P_EX  = 6'b001111;
   localparam logic [5:0] P_ALL = 6'b111111;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, stallreq_ex, excp_req;
   logic [31:0] excp_pc;
   logic [5:0]  stall;
   logic        flush, timeout_err;
   logic [31:0] new_pc, stall_cycles;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: error flag, pending flush, latched pc, counters
   bit          m_err, m_flush;
   logic [31:0] m_pc, m_cyc;
   int          m_run;
   logic [5:0]  es;

   pipe_ctrl #(.MAX_EX_STALL(MAX)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .excp_req     (excp_req),
      .excp_pc      (excp_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .timeout_err  (timeout_err),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_err = 0; m_flush = 0; m_pc = 32'h0; m_cyc = 32'h0; m_run = 0;
      end
      if (m_err)                     es = P_ALL;
      else if (m_flush || excp_req)  es = 6'b0;
      else if (stallreq_ex)          es = P_EX;
      else if (stallreq_id)          es = P_ID;
      else                           es = 6'b0;
      chk("model_stall", 32'(stall), 32'(es));
      chk("model_flush", 32'(flush), 32'(m_flush));
      chk("model_new_pc", new_pc, m_pc);
      chk("model_timeout", 32'(timeout_err), 32'(m_err));
      chk("model_stall_cycles", stall_cycles, m_cyc);
      if (rst) begin
         if (es[0] && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
         if (!m_err) begin
            if (excp_req) m_pc = excp_pc;
            m_run   = (es == P_EX) ? m_run + 1 : 0;
            m_flush = excp_req;
            if (m_run >= MAX) begin
               m_err   = 1;
               m_flush = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit id, input bit ex, input bit xr, input logic [31:0] pc);
      stallreq_id = id; stallreq_ex = ex; excp_req = xr; excp_pc = pc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ex_left;
      rst = 1'b0;
      drive(0, 0, 0, 32'h0);
      #2;
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_flush", 32'(flush), 32'h0);
      chk("reset_new_pc", new_pc, 32'h0);
      chk("reset_timeout", 32'(timeout_err), 32'h0);
      chk("reset_cycles", stall_cycles, 32'h0);
      step(); step();
      rst = 1'b1;

      // single-cycle load-use stall
      step(); drive(1, 0, 0, 32'h0);
      @(negedge clk); chk("id_stall", 32'(stall), 32'(P_ID)); chk("id_cycles0", stall_cycles, 0);
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("id_release", 32'(stall), 0); chk("id_cycles1", stall_cycles, 1);

      // EX stall just under the watchdog limit
      for (int i = 0; i < 3; i++) begin
         step(); drive(0, 1, 0, 32'h0);
         @(negedge clk); chk("ex3_stall", 32'(stall), 32'(P_EX));
      end
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("ex3_release", 32'(stall), 0); chk("ex3_timeout", 32'(timeout_err), 0);
      step();
      @(negedge clk); chk("ex3_timeout_late", 32'(timeout_err), 0);

      // exception beats EX stall
      step(); drive(0, 1, 1, 32'hBFC0_0380);
      @(negedge clk); chk("excp_stall", 32'(stall), 0);
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("excp_flush", 32'(flush), 1); chk("excp_pc", new_pc, 32'hBFC0_0380);
      step();
      @(negedge clk); chk("excp_flush_end", 32'(flush), 0); chk("excp_pc_hold", new_pc, 32'hBFC0_0380);

      // back-to-back redirects
      step(); drive(0, 0, 1, 32'h100);
      @(negedge clk); chk("b2b_noflush", 32'(flush), 0);
      step(); drive(0, 0, 1, 32'h200);
      @(negedge clk); chk("b2b_flush1", 32'(flush), 1); chk("b2b_pc1", new_pc, 32'h100);
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("b2b_flush2", 32'(flush), 1); chk("b2b_pc2", new_pc, 32'h200);
      step();
      @(negedge clk); chk("b2b_flush_end", 32'(flush), 0);

      // watchdog expiry at exactly MAX consecutive EX stalls
      for (int i = 0; i < MAX; i++) begin
         step(); drive(0, 1, 0, 32'h0);
         @(negedge clk); chk("ex4_stall", 32'(stall), 32'(P_EX)); chk("ex4_no_err", 32'(timeout_err), 0);
      end
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("err_timeout", 32'(timeout_err), 1); chk("err_stall", 32'(stall), 32'(P_ALL));
      for (int i = 0; i < 3; i++) begin
         step(); drive(1, 0, 1, 32'hDEAD_BEEF);
         @(negedge clk);
         chk("err_sticky", 32'(timeout_err), 1); chk("err_stall_hold", 32'(stall), 32'(P_ALL));
         chk("err_pc_hold", new_pc, 32'h200); chk("err_noflush", 32'(flush), 0);
      end
      step(); drive(0, 0, 0, 32'h0); rst = 1'b0;
      step(); rst = 1'b1;
      @(negedge clk); chk("err_reset_timeout", 32'(timeout_err), 0); chk("err_reset_stall", 32'(stall), 0);

      // async reset while in EX_WAIT with five stall cycles counted
      for (int i = 0; i < 3; i++) begin step(); drive(1, 0, 0, 32'h0); end
      for (int i = 0; i < 3; i++) begin step(); drive(0, 1, 0, 32'h0); end
      @(negedge clk); chk("mid_cycles5", stall_cycles, 5); chk("mid_stall_ex", 32'(stall), 32'(P_EX));
      #2; rst = 1'b0; drive(0, 0, 0, 32'h0);
      #1;
      chk("async_cycles", stall_cycles, 0); chk("async_stall", 32'(stall), 0);
      chk("async_flush", 32'(flush), 0); chk("async_timeout", 32'(timeout_err), 0);
      chk("async_new_pc", new_pc, 0);
      step(); step(); rst = 1'b1;
      @(negedge clk); chk("post_rst_stall", 32'(stall), 0); chk("post_rst_cycles", stall_cycles, 0);
      for (int i = 0; i < 3; i++) begin step(); drive(0, 1, 0, 32'h0); end
      step(); drive(0, 0, 0, 32'h0);
      @(negedge clk); chk("post_rst_no_err", 32'(timeout_err), 0); chk("post_rst_cycles3", stall_cycles, 3);

      // random traffic
      ex_left = 0;
      for (int c = 0; c < 4000; c++) begin
         step();
         if (ex_left == 0 && $urandom_range(0, 5) == 0) ex_left = int'($urandom_range(1, 6));
         drive($urandom_range(0, 3) == 0, ex_left != 0, $urandom_range(0, 15) == 0, $urandom);
         if (ex_left != 0) ex_left--;
         rst = ($urandom_range(0, 149) != 0);
      end
      step(); drive(0, 0, 0, 32'h0); rst = 1'b1;
      step();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
